// File: rtl/svc_rv_stage_wb_ctl_pkg.sv
// Shared definitions for the RISC-V write-back stage.
//   I_EBREAK   - encoding of the EBREAK instruction
//   wb_state_t - write-back control FSM states
package svc_rv_stage_wb_ctl_pkg;

  localparam logic [31:0] I_EBREAK = 32'h0010_0073;

  typedef enum logic {
    WB_RUN    = 1'b0,
    WB_HALTED = 1'b1
  } wb_state_t;

endpackage

// File: rtl/svc_muxn.sv
// N-way one-hot-free select of WIDTH-bit lanes.
//   sel_i  - lane index; an index with no matching lane yields 0
//   data_i - packed lanes, lane k = data_i[k*WIDTH +: WIDTH]
//   data_o - selected lane
module svc_muxn #(
  parameter  int WIDTH = 32,
  parameter  int N     = 6,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [N*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_i == SEL_W'(k)) data_o = data_i[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/svc_rv_retire_cnt.sv
// Wrapping event counter (instret, cycle counts).
//   inc_i   - add one this cycle
//   clr_i   - force zero next cycle; takes priority over inc_i
//   count_o - current count, wraps modulo 2^CNT_W
module svc_rv_retire_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/svc_rv_stage_wb_ctl.sv
// RISC-V write-back stage: optional output register, N-way result select,
// register-file write port / forwarding tap, instret counter, EBREAK halt.
//   in_*          - MEM-stage instruction with valid/ready handshake
//   rd_wen/addr/data - register-file write port (rd_data doubles as fwd tap)
//   retire/ebreak - retire strobe and EBREAK retire pulse
//   halted/resume - debug halt status and release
//   instret(_clr) - retired-instruction count and synchronous clear
//
// state     | meaning
// WB_RUN    | accepting and retiring instructions
// WB_HALTED | EBREAK retired, nothing accepted until resume
module svc_rv_stage_wb_ctl
  import svc_rv_stage_wb_ctl_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int NUM_SRC = 6,
  parameter  int REG_OUT = 1,
  parameter  int CNT_W   = 64,
  localparam int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic                    in_reg_wr,
  input  logic [4:0]              in_rd,
  input  logic [SEL_W-1:0]        in_res_src,
  input  logic [NUM_SRC*XLEN-1:0] in_res,
  output logic                    rd_wen,
  output logic [4:0]              rd_addr,
  output logic [XLEN-1:0]         rd_data,
  output logic                    retire,
  output logic                    ebreak,
  output logic                    halted,
  input  logic                    resume,
  input  logic                    instret_clr,
  output logic [CNT_W-1:0]        instret
);

  localparam logic [SEL_W:0] SRC_LIM = (SEL_W+1)'(NUM_SRC);

  wb_state_t state_q;

  logic                    stg_valid;
  logic [31:0]             stg_instr;
  logic                    stg_reg_wr;
  logic [4:0]              stg_rd;
  logic [SEL_W-1:0]        stg_src;
  logic [NUM_SRC*XLEN-1:0] stg_res;
  logic                    stg_ebreak;

  assign stg_ebreak = (stg_instr == I_EBREAK);

  generate
    if (REG_OUT != 0) begin : g_reg
      logic                    valid_q;
      logic [31:0]             instr_q;
      logic                    reg_wr_q;
      logic [4:0]              rd_q;
      logic [SEL_W-1:0]        src_q;
      logic [NUM_SRC*XLEN-1:0] res_q;
      logic                    accept;

      assign accept = in_valid && in_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q  <= 1'b0;
          instr_q  <= '0;
          reg_wr_q <= 1'b0;
          rd_q     <= '0;
          src_q    <= '0;
          res_q    <= '0;
        end else begin
          valid_q <= accept;
          if (accept) begin
            instr_q  <= in_instr;
            reg_wr_q <= in_reg_wr;
            rd_q     <= in_rd;
            src_q    <= in_res_src;
            res_q    <= in_res;
          end
        end
      end

      assign stg_valid  = valid_q;
      assign stg_instr  = instr_q;
      assign stg_reg_wr = reg_wr_q;
      assign stg_rd     = rd_q;
      assign stg_src    = src_q;
      assign stg_res    = res_q;
      // Blocks the instruction queued behind a retiring EBREAK.
      assign in_ready   = (state_q == WB_RUN) && !(stg_valid && stg_ebreak);
    end else begin : g_comb
      assign stg_valid  = in_valid && in_ready;
      assign stg_instr  = in_instr;
      assign stg_reg_wr = in_reg_wr;
      assign stg_rd     = in_rd;
      assign stg_src    = in_res_src;
      assign stg_res    = in_res;
      // The stage is the input, so the EBREAK term would only loop back on
      // itself; the instruction after an EBREAK arrives once HALTED anyway.
      assign in_ready   = (state_q == WB_RUN);
    end
  endgenerate

  logic [XLEN-1:0] mux_data;
  logic [XLEN-1:0] sel_data;
  logic [4:0]      addr_q;
  logic [XLEN-1:0] data_q;

  svc_muxn #(.WIDTH(XLEN), .N(NUM_SRC)) u_mux (
    .sel_i  (stg_src),
    .data_i (stg_res),
    .data_o (mux_data)
  );

  assign sel_data = ({1'b0, stg_src} < SRC_LIM) ? mux_data : '0;

  assign retire = stg_valid;
  assign rd_wen = retire && stg_reg_wr && (stg_rd != 5'd0);
  assign ebreak = retire && stg_ebreak;

  // Write port holds its last retired value between retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (retire) begin
      addr_q <= stg_rd;
      data_q <= sel_data;
    end
  end

  assign rd_addr = retire ? stg_rd : addr_q;
  assign rd_data = retire ? sel_data : data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WB_RUN;
    end else begin
      case (state_q)
        WB_RUN:    if (ebreak) state_q <= WB_HALTED;
        WB_HALTED: if (resume) state_q <= WB_RUN;
        default:   state_q <= WB_RUN;
      endcase
    end
  end

  assign halted = (state_q == WB_HALTED);

  svc_rv_retire_cnt #(.CNT_W(CNT_W)) u_instret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (retire),
    .clr_i   (instret_clr),
    .count_o (instret)
  );

endmodule

// File: tb/tb_svc_rv_stage_wb_ctl.sv
module tb_svc_rv_stage_wb_ctl;

  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] ADDI = 32'h0050_0293;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // shared stimulus for dut_a (REG_OUT=1, 64-bit) and dut_b (REG_OUT=1, 4-bit)
  logic         valid, reg_wr, resume, clr;
  logic [31:0]  instr;
  logic [4:0]   rd;
  logic [2:0]   src;
  logic [191:0] res;

  // stimulus for dut_c (REG_OUT=0)
  logic         c_valid, c_reg_wr, c_resume, c_clr;
  logic [31:0]  c_instr;
  logic [4:0]   c_rd;
  logic [2:0]   c_src;
  logic [191:0] c_res;

  logic        a_rdy, a_wen, a_ret, a_ebk, a_hlt;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic [63:0] a_cnt;
  logic        b_rdy, b_wen, b_ret, b_ebk, b_hlt;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic [3:0]  b_cnt;
  logic        c_rdy, c_wen, c_ret, c_ebk, c_hlt;
  logic [4:0]  c_addr;
  logic [31:0] c_data;
  logic [63:0] c_cnt;

  svc_rv_stage_wb_ctl #(.REG_OUT(1), .CNT_W(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(valid), .in_ready(a_rdy), .in_instr(instr),
    .in_reg_wr(reg_wr), .in_rd(rd), .in_res_src(src), .in_res(res),
    .rd_wen(a_wen), .rd_addr(a_addr), .rd_data(a_data), .retire(a_ret), .ebreak(a_ebk),
    .halted(a_hlt), .resume(resume), .instret_clr(clr), .instret(a_cnt));

  svc_rv_stage_wb_ctl #(.REG_OUT(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(valid), .in_ready(b_rdy), .in_instr(instr),
    .in_reg_wr(reg_wr), .in_rd(rd), .in_res_src(src), .in_res(res),
    .rd_wen(b_wen), .rd_addr(b_addr), .rd_data(b_data), .retire(b_ret), .ebreak(b_ebk),
    .halted(b_hlt), .resume(resume), .instret_clr(clr), .instret(b_cnt));

  svc_rv_stage_wb_ctl #(.REG_OUT(0), .CNT_W(64)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_rdy), .in_instr(c_instr),
    .in_reg_wr(c_reg_wr), .in_rd(c_rd), .in_res_src(c_src), .in_res(c_res),
    .rd_wen(c_wen), .rd_addr(c_addr), .rd_data(c_data), .retire(c_ret), .ebreak(c_ebk),
    .halted(c_hlt), .resume(c_resume), .instret_clr(c_clr), .instret(c_cnt));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 0; reg_wr = 0; resume = 0; clr = 0; instr = '0; rd = '0; src = '0; res = '0;
    c_valid = 0; c_reg_wr = 0; c_resume = 0; c_clr = 0; c_instr = '0; c_rd = '0;
    c_src = '0; c_res = '0;
    #12;
    chk("rst_retire", {63'd0, a_ret}, 64'd0);
    chk("rst_instret", a_cnt, 64'd0);
    chk("rst_halted", {63'd0, a_hlt}, 64'd0);
    chk("rst_rd_addr", {59'd0, a_addr}, 64'd0);
    chk("rst_rd_data", {32'd0, a_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // back-to-back ADDIs, REG_OUT=1
    valid = 1; instr = ADDI; reg_wr = 1; src = 3'd0;
    for (int i = 0; i < 3; i++) begin
      rd = 5'(5 + i);
      res[31:0] = 32'h1234 + 32'(i);
      if (i == 0) begin
        #1 chk("pre_wen", {63'd0, a_wen}, 64'd0);
      end
      tick();
      chk("addi_wen", {63'd0, a_wen}, 64'd1);
      chk("addi_addr", {59'd0, a_addr}, 64'(5 + i));
      chk("addi_data", {32'd0, a_data}, 64'(32'h1234 + 32'(i)));
      chk("addi_instret", a_cnt, 64'(i));
    end
    valid = 0;
    tick();
    chk("idle_retire", {63'd0, a_ret}, 64'd0);
    chk("hold_addr", {59'd0, a_addr}, 64'd7);
    chk("hold_data", {32'd0, a_data}, 64'h1236);
    chk("cnt3", a_cnt, 64'd3);

    // rd=0 then out-of-range select
    valid = 1; rd = 5'd0; src = 3'd2; res[64 +: 32] = 32'hAAAA;
    tick();
    chk("x0_retire", {63'd0, a_ret}, 64'd1);
    chk("x0_wen", {63'd0, a_wen}, 64'd0);
    chk("x0_data", {32'd0, a_data}, 64'hAAAA);
    rd = 5'd9; src = 3'd7;
    tick();
    chk("src7_wen", {63'd0, a_wen}, 64'd1);
    chk("src7_data", {32'd0, a_data}, 64'd0);
    chk("cnt4", a_cnt, 64'd4);
    valid = 0;
    tick();
    chk("cnt5", a_cnt, 64'd5);

    // EBREAK followed by ADDI
    valid = 1; instr = EBRK; reg_wr = 0; rd = 5'd0;
    tick();
    chk("ebk_pulse", {63'd0, a_ebk}, 64'd1);
    chk("ebk_ready", {63'd0, a_rdy}, 64'd0);
    chk("ebk_halted", {63'd0, a_hlt}, 64'd0);
    instr = ADDI; reg_wr = 1; rd = 5'd10; src = 3'd0; res[31:0] = 32'hBEEF;
    tick();
    chk("ebk_one_cycle", {63'd0, a_ebk}, 64'd0);
    chk("halted", {63'd0, a_hlt}, 64'd1);
    chk("halt_ready", {63'd0, a_rdy}, 64'd0);
    chk("halt_noret", {63'd0, a_ret}, 64'd0);
    chk("cnt_ebk", a_cnt, 64'd6);
    tick();
    chk("still_halted", {63'd0, a_hlt}, 64'd1);
    chk("cnt_halt", a_cnt, 64'd6);
    resume = 1;
    tick();
    resume = 0;
    chk("resumed", {63'd0, a_hlt}, 64'd0);
    chk("resume_ready", {63'd0, a_rdy}, 64'd1);
    chk("resume_noret", {63'd0, a_ret}, 64'd0);
    tick();
    chk("post_addr", {59'd0, a_addr}, 64'd10);
    chk("post_data", {32'd0, a_data}, 64'hBEEF);
    valid = 0;
    tick();
    chk("cnt7", a_cnt, 64'd7);

    // resume coincident with EBREAK retire
    valid = 1; instr = EBRK; reg_wr = 0;
    tick();
    valid = 0; resume = 1;
    #1 chk("ebk2_pulse", {63'd0, a_ebk}, 64'd1);
    tick();
    resume = 0;
    chk("ebk2_halted", {63'd0, a_hlt}, 64'd1);
    chk("cnt8", a_cnt, 64'd8);
    resume = 1;
    tick();
    chk("ebk2_resumed", {63'd0, a_hlt}, 64'd0);
    tick();
    resume = 0;
    chk("run_resume", {63'd0, a_hlt}, 64'd0);
    chk("run_ready", {63'd0, a_rdy}, 64'd1);

    // clear wins over retire, then 4-bit wrap
    valid = 1; instr = ADDI; reg_wr = 1; rd = 5'd3;
    tick();
    valid = 0; clr = 1;
    tick();
    clr = 0;
    chk("clr_a", a_cnt, 64'd0);
    chk("clr_b", {60'd0, b_cnt}, 64'd0);
    valid = 1;
    repeat (15) tick();
    valid = 0;
    tick();
    chk("b_15", {60'd0, b_cnt}, 64'd15);
    valid = 1;
    tick();
    valid = 0;
    tick();
    chk("b_wrap", {60'd0, b_cnt}, 64'd0);
    chk("a_16", a_cnt, 64'd16);

    // reset with an entry in the stage register
    valid = 1;
    tick();
    chk("mid_retire", {63'd0, a_ret}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_retire", {63'd0, a_ret}, 64'd0);
    chk("midrst_cnt", a_cnt, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 0;
    tick();
    chk("midrst_ready", {63'd0, a_rdy}, 64'd1);
    chk("midrst_noret", {63'd0, a_ret}, 64'd0);
    chk("midrst_cnt2", a_cnt, 64'd0);

    // REG_OUT=0: same-cycle write port and ebreak
    c_valid = 1; c_instr = ADDI; c_reg_wr = 1; c_rd = 5'd0; c_src = 3'd7;
    c_res[31:0] = 32'h1234;
    #1;
    chk("c_x0_retire", {63'd0, c_ret}, 64'd1);
    chk("c_x0_wen", {63'd0, c_wen}, 64'd0);
    chk("c_src7_data", {32'd0, c_data}, 64'd0);
    tick();
    c_rd = 5'd5; c_src = 3'd0;
    #1;
    chk("c_wen", {63'd0, c_wen}, 64'd1);
    chk("c_addr", {59'd0, c_addr}, 64'd5);
    chk("c_data", {32'd0, c_data}, 64'h1234);
    chk("c_cnt1", c_cnt, 64'd1);
    tick();
    c_valid = 0;
    #1;
    chk("c_hold_addr", {59'd0, c_addr}, 64'd5);
    chk("c_hold_data", {32'd0, c_data}, 64'h1234);
    chk("c_cnt2", c_cnt, 64'd2);
    c_valid = 1; c_instr = EBRK; c_reg_wr = 0;
    #1;
    chk("c_ebk", {63'd0, c_ebk}, 64'd1);
    tick();
    c_instr = ADDI; c_reg_wr = 1; c_rd = 5'd11; c_res[31:0] = 32'hCAFE;
    #1;
    chk("c_halted", {63'd0, c_hlt}, 64'd1);
    chk("c_halt_ready", {63'd0, c_rdy}, 64'd0);
    chk("c_halt_noret", {63'd0, c_ret}, 64'd0);
    chk("c_ebk_off", {63'd0, c_ebk}, 64'd0);
    chk("c_cnt3", c_cnt, 64'd3);
    c_resume = 1;
    tick();
    c_resume = 0;
    #1;
    chk("c_resumed", {63'd0, c_hlt}, 64'd0);
    chk("c_post_wen", {63'd0, c_wen}, 64'd1);
    chk("c_post_data", {32'd0, c_data}, 64'hCAFE);
    tick();
    c_valid = 0;
    chk("c_cnt4", c_cnt, 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
